// File: rtl/prog_clk_div.sv
// prog_clk_div: programmable clock divider / duty-cycle generator with glitch-free reconfiguration
`timescale 1ns/1ps
module prog_clk_div #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             active
);
    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] pend_period_q, pend_high_q;
    logic             has_cfg_q, has_cfg_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             rise_q, fall_q, err_q;
    logic             xfer, legal, boundary, apply;

    assign xfer     = cfg_valid && !pend_q;
    assign legal    = (cfg_period >= CNT_W'(2)) && (cfg_high != '0) && (cfg_high < cfg_period);
    assign boundary = (state_q == RUN) && (cnt_q == period_q - CNT_W'(1));
    // Pending values land immediately when idle, otherwise only between periods
    assign apply    = pend_q && ((state_q == IDLE) || boundary);

    assign cfg_ready  = !pend_q;
    assign cfg_err    = err_q;
    assign clk_out    = clk_out_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign active     = (state_q == RUN);

    // Next state: config hand-over, run/idle decision and waveform position
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        period_d  = apply ? pend_period_q : period_q;
        high_d    = apply ? pend_high_q : high_q;
        has_cfg_d = has_cfg_q | apply;
        pend_d    = apply ? 1'b0 : (pend_q | (xfer && legal));
        if (state_q == IDLE) begin
            if (en && has_cfg_d) begin
                state_d   = RUN;
                cnt_d     = '0;
                clk_out_d = 1'b1;
            end
        end else if (boundary) begin
            // high time is at least one cycle, so a continuing run always re-rises here
            state_d   = en ? RUN : IDLE;
            cnt_d     = '0;
            clk_out_d = en;
        end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            clk_out_d = cnt_d < high_q;
        end
    end

    // State, counter and configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            period_q      <= '0;
            high_q        <= '0;
            has_cfg_q     <= 1'b0;
            pend_q        <= 1'b0;
            pend_period_q <= '0;
            pend_high_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            has_cfg_q <= has_cfg_d;
            pend_q    <= pend_d;
            if (xfer && legal) begin
                pend_period_q <= cfg_period;
                pend_high_q   <= cfg_high;
            end
        end
    end

    // Registered waveform, edge strobes and rejection pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_out_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            clk_out_q <= clk_out_d;
            rise_q    <= clk_out_d & ~clk_out_q;
            fall_q    <= ~clk_out_d & clk_out_q;
            err_q     <= xfer && !legal;
        end
    end
endmodule

// File: tb/tb_prog_clk_div.sv
// tb_prog_clk_div: randomized and directed checks of prog_clk_div against a period-position model
`timescale 1ns/1ps
module tb_prog_clk_div;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [CNT_W-1:0] cfg_high = '0;
    logic             cfg_ready, cfg_err, clk_out, rise_pulse, fall_pulse, active;
    logic [5:0]       outs;

    int checks = 0;
    int fails = 0;

    // Model: whether running, position inside the current period, applied and pending configs
    bit m_run, m_has, m_pend, m_err;
    int m_pos, m_per, m_hi, m_pp, m_ph;

    prog_clk_div #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_ready(cfg_ready),
        .cfg_err(cfg_err), .clk_out(clk_out), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .active(active)
    );

    always #5 clk = ~clk;

    assign outs = {clk_out, rise_pulse, fall_pulse, active, cfg_ready, cfg_err};

    // Expected outputs follow directly from the position within the period
    function automatic logic [5:0] exp_v();
        return {m_run && m_pos < m_hi, m_run && m_pos == 0, m_run && m_pos == m_hi,
                m_run, !m_pend, m_err};
    endfunction

    task automatic model_reset();
        m_run = 0; m_has = 0; m_pend = 0; m_err = 0;
        m_pos = 0; m_per = 0; m_hi = 0; m_pp = 0; m_ph = 0;
    endtask

    task automatic model_apply();
        m_per = m_pp; m_hi = m_ph; m_has = 1; m_pend = 0;
    endtask

    task automatic model_step();
        bit legal, take, wrap;
        legal = int'(cfg_period) >= 2 && int'(cfg_high) >= 1 && int'(cfg_high) < int'(cfg_period);
        take  = cfg_valid && !m_pend;
        wrap  = m_run && m_pos == m_per - 1;
        if (!m_run) begin
            if (m_pend) model_apply();
            if (en && m_has) begin
                m_run = 1;
                m_pos = 0;
            end
        end else if (wrap) begin
            if (m_pend) model_apply();
            m_run = en;
            m_pos = 0;
        end else begin
            m_pos++;
        end
        if (take && legal) begin
            m_pend = 1;
            m_pp = int'(cfg_period);
            m_ph = int'(cfg_high);
        end
        m_err = take && !legal;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        #1 model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic offer(input int p, input int h);
        cfg_valid = 1'b1;
        cfg_period = CNT_W'(p);
        cfg_high = CNT_W'(h);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1 model_reset();
        step();
        checks++;
        if (outs !== exp_v()) begin
            fails++;
            $display("FAIL reset: clk/rise/fall/act/rdy/err got %b expected %b", outs, exp_v());
        end
        checks++;
        if (cfg_ready !== 1'b1 || clk_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: ready %b clk_out %b expected 1 0", cfg_ready, clk_out);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int highs = 0;
        int rises = 0;
        en = 1'b1;
        offer(10, 7);
        step();
        cfg_valid = 1'b0;
        checks++;
        if (outs !== exp_v() || cfg_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_capture: got %b expected %b", outs, exp_v());
        end
        for (int i = 0; i < 40; i++) begin
            step();
            highs += int'(clk_out);
            rises += int'(rise_pulse);
            checks++;
            if (outs !== exp_v()) begin
                fails++;
                $display("FAIL basic cyc %0d: got %b expected %b", i, outs, exp_v());
            end
        end
        checks++;
        if (highs != 28 || rises != 4) begin
            fails++;
            $display("FAIL basic_duty: highs %0d rises %0d expected 28 4", highs, rises);
        end
    endtask

    task automatic test_illegal();
        int ps[5] = '{1, 5, 5, 0, 3};
        int hs[5] = '{0, 5, 0, 0, 4};
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            offer(ps[k], hs[k]);
            step();
            cfg_valid = 1'b0;
            checks++;
            if (outs !== exp_v() || cfg_err !== 1'b1) begin
                fails++;
                $display("FAIL illegal_err %0d/%0d: got %b expected %b", ps[k], hs[k], outs, exp_v());
            end
            step();
            checks++;
            if (outs !== exp_v() || cfg_err !== 1'b0 || active !== 1'b0) begin
                fails++;
                $display("FAIL illegal_after %0d/%0d: got %b expected %b", ps[k], hs[k], outs, exp_v());
            end
        end
    endtask

    task automatic run_to_pos(input int p, input string tag);
        int guard = 0;
        while (!(m_run && m_pos == p) && guard < 40) begin
            step();
            guard++;
            checks++;
            if (outs !== exp_v()) begin
                fails++;
                $display("FAIL %s wait: got %b expected %b", tag, outs, exp_v());
            end
        end
        checks++;
        if (guard >= 40) begin
            fails++;
            $display("FAIL %s timeout: position %0d never reached, at %0d", tag, p, m_pos);
        end
    endtask

    task automatic check_run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            checks++;
            if (outs !== exp_v()) begin
                fails++;
                $display("FAIL %s cyc %0d: got %b expected %b", tag, i, outs, exp_v());
            end
        end
    endtask

    task automatic test_reconfig();
        do_reset();
        en = 1'b1;
        offer(10, 7);
        step();
        cfg_valid = 1'b0;
        run_to_pos(3, "reconfig");
        offer(4, 1);
        step();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0 || outs !== exp_v()) begin
            fails++;
            $display("FAIL reconfig_pending: got %b expected %b", outs, exp_v());
        end
        check_run(30, "reconfig");
    endtask

    task automatic test_drop_en();
        do_reset();
        en = 1'b1;
        offer(10, 7);
        step();
        cfg_valid = 1'b0;
        run_to_pos(2, "glitch_en");
        en = 1'b0;
        step();
        en = 1'b1;
        check_run(15, "glitch_en");
        run_to_pos(2, "drop_en");
        en = 1'b0;
        check_run(12, "drop_en");
        checks++;
        if (active !== 1'b0 || clk_out !== 1'b0) begin
            fails++;
            $display("FAIL drop_en_idle: active %b clk_out %b expected 0 0", active, clk_out);
        end
        en = 1'b1;
        step();
        checks++;
        if (outs !== exp_v() || rise_pulse !== 1'b1) begin
            fails++;
            $display("FAIL drop_en_restart: got %b expected %b", outs, exp_v());
        end
        check_run(12, "restart");
    endtask

    task automatic test_midreset();
        do_reset();
        en = 1'b1;
        offer(10, 7);
        step();
        cfg_valid = 1'b0;
        run_to_pos(3, "midreset");
        #2 rst_n = 1'b0;
        #1 model_reset();
        checks++;
        if (outs !== exp_v() || clk_out !== 1'b0 || active !== 1'b0) begin
            fails++;
            $display("FAIL midreset_async: got %b expected %b", outs, exp_v());
        end
        step();
        rst_n = 1'b1;
        check_run(6, "midreset_nocfg");
        checks++;
        if (active !== 1'b0) begin
            fails++;
            $display("FAIL midreset_idle: active %b expected 0", active);
        end
    endtask

    task automatic test_min();
        do_reset();
        en = 1'b1;
        offer(2, 1);
        step();
        cfg_valid = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (outs !== exp_v() || rise_pulse === fall_pulse) begin
                fails++;
                $display("FAIL min cyc %0d: got %b expected %b", i, outs, exp_v());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_period = CNT_W'($urandom_range(0, 9));
            cfg_high = CNT_W'($urandom_range(0, 9));
            if ($urandom_range(0, 19) == 0) en = ~en;
            step();
            checks++;
            if (outs !== exp_v()) begin
                fails++;
                $display("FAIL random cyc %0d: got %b expected %b", i, outs, exp_v());
            end
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_illegal();
        test_reconfig();
        test_drop_en();
        test_midreset();
        test_min();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/prog_clk_div.md
Name: prog_clk_div

Overview:
Synthesizable programmable clock divider/duty-cycle generator that consumes the free-running system clock (100 MHz in the team's benches) and produces a derived clock-enable waveform of programmable period and high-time. It is the RTL counterpart of the behavioural frequency/duty clock source and drives downstream blocks needing slower, duty-controlled strobes. Configuration changes are accepted through a valid/ready handshake and applied only at period boundaries, so the output never glitches.

Parameters:
CNT_W, 16, width of period/high-time counters and config fields (max period 2^CNT_W-1 cycles).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  run request; level-sensitive
cfg_valid  input  1  new config offered
cfg_period  input  CNT_W  period in clk cycles
cfg_high  input  CNT_W  high-time in clk cycles
cfg_ready  output  1  block can accept a config this cycle
cfg_err  output  1  one-cycle pulse: offered config rejected
clk_out  output  1  divided clock, registered
rise_pulse  output  1  one-cycle pulse in the cycle clk_out goes 0->1
fall_pulse  output  1  one-cycle pulse in the cycle clk_out goes 1->0
active  output  1  high while in RUN

Behaviour:
- Reset (async assert, sync release by clk): state=IDLE, cnt=0, period_q=0, high_q=0, has_cfg=0, pend=0, clk_out=0, rise/fall_pulse=0, cfg_err=0, active=0, cfg_ready=1. Mid-operation reset forces clk_out low immediately, no waveform completion.
- Config legality: 2 <= cfg_period and 1 <= cfg_high <= cfg_period-1. Others rejected.
- Handshake: transfer when cfg_valid && cfg_ready. Legal -> captured into pending regs, pend=1. Illegal -> cfg_err=1 next cycle, nothing captured, pend unchanged. cfg_ready = !pend.
- Pending apply: IDLE -> pending copied to period_q/high_q the cycle after capture, has_cfg=1, pend=0. RUN -> copied at period boundary (cnt==period_q-1); new period starts with new values on next cycle.
- States: IDLE, RUN.
  IDLE->RUN: en=1 && has_cfg=1 (a config applied this same cycle counts). Next cycle: cnt=0, clk_out=1, rise_pulse=1, active=1.
  RUN->IDLE: en=0 sampled at period boundary only; current period always completes. clk_out stays 0, active=0 from next cycle. en deassert/reassert within one period has no effect.
- RUN counting: cnt_next = (cnt==period_q-1) ? 0 : cnt+1; clk_out_next = (cnt_next < high_q) using values active for that period. Result: clk_out high exactly high_q cycles, low period_q-high_q cycles, period exactly period_q cycles.
- rise_pulse/fall_pulse registered alongside clk_out, asserted the same cycle clk_out changes; never both.
- Simultaneous: config applied at boundary while en=0 -> block goes IDLE, new values retained for next start. cfg_valid while pend=1 ignored (no cfg_err).
- Widths: all compares unsigned CNT_W bits; no wrap possible since cnt < period_q.

Test Plan:
- Reset, cfg 10/7, en=1 -> cfg_ready deasserts one cycle; clk_out 1 for 7 cycles, 0 for 3, repeating (10 MHz, 70%); rise_pulse every 10 cycles.
- Illegal configs 1/0, 5/5, 5/0 -> cfg_err one-cycle pulse each, period_q unchanged, no output activity.
- Running 10/7, offer 4/1 at cnt=3 -> current 10-cycle period completes intact, then 1 high/3 low; cfg_ready returns 1 the cycle after apply.
- Drop en at cnt=2 of 10/7 -> remaining 8 cycles produced, then clk_out=0, active=0; re-raise en -> restart at cnt=0 with rise_pulse.
- Assert rst_n=0 mid-high phase -> clk_out, active, pulses 0 immediately; after release, en=1 without new cfg -> stays IDLE.
- Minimum 2/1 -> clk_out toggles every cycle, rise/fall_pulse alternate every cycle.
